// File: rtl/dmem_port_arbiter_if.sv
// Two-requester data-memory bus plus the shared Data_Memory side.
// slave = arbiter view, master = requesters/memory view.
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req0, we0, gnt0, rvalid0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0, rdata0;
   logic              req1, we1, gnt1, rvalid1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1, rdata1;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wd, mem_rd;
   logic              busy;

   modport slave (
      input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rd,
      output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
             mem_we, mem_addr, mem_wd, busy
   );

   modport master (
      output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rd,
      input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
             mem_we, mem_addr, mem_wd, busy
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between core (port 0) and debug loader (port 1): ACCEPT -> ISSUE -> read return.
// Define ARB_CORE_PRIO_EN for fixed priority to port 0 instead of round-robin.
module dmem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   dmem_port_arbiter_if.slave bus
);
   localparam int NP = 2;

   typedef struct packed {
      logic              port;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   logic [NP-1:0]             req, gnt;
   cmd_t [NP-1:0]             cand;
   cmd_t                      cmd_q, cmd_d;
   logic                      cmd_vld_q, cmd_vld_d;
   logic [NP-1:0]             rvalid_q, rvalid_d;
   logic [NP-1:0][DATA_W-1:0] rdata_q, rdata_d;

   assign req     = {bus.req1, bus.req0};
   assign cand[0] = '{port: 1'b0, we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
   assign cand[1] = '{port: 1'b1, we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};

   // Grants are combinational but forced low while reset is held.
`ifdef ARB_CORE_PRIO_EN
   always_comb begin
      gnt = '0;
      if (reset) begin
         if (req[0])      gnt[0] = 1'b1;
         else if (req[1]) gnt[1] = 1'b1;
      end
   end
`else
   logic rr_ptr_q, rr_ptr_d;

   always_comb begin
      gnt = '0;
      if (reset) begin
         if (req[0] && (!req[1] || !rr_ptr_q)) gnt[0] = 1'b1;
         else if (req[1])                      gnt[1] = 1'b1;
      end
      rr_ptr_d = rr_ptr_q;
      if (gnt[0])      rr_ptr_d = 1'b1;
      else if (gnt[1]) rr_ptr_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rr_ptr_q <= 1'b0;
      else        rr_ptr_q <= rr_ptr_d;
   end
`endif

   // Command register keeps addr/wdata when idle so the memory bus does not glitch.
   always_comb begin
      cmd_vld_d = |gnt;
      cmd_d     = cmd_q;
      if (gnt[1])      cmd_d = cand[1];
      else if (gnt[0]) cmd_d = cand[0];
      for (int i = 0; i < NP; i++) begin
         rvalid_d[i] = cmd_vld_q && !cmd_q.we && (int'(cmd_q.port) == i);
         rdata_d[i]  = rvalid_d[i] ? bus.mem_rd : rdata_q[i];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_vld_q <= 1'b0;
         cmd_q     <= '0;
         rvalid_q  <= '0;
         rdata_q   <= '0;
      end else begin
         cmd_vld_q <= cmd_vld_d;
         cmd_q     <= cmd_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   assign bus.gnt0     = gnt[0];
   assign bus.gnt1     = gnt[1];
   assign bus.rvalid0  = rvalid_q[0];
   assign bus.rvalid1  = rvalid_q[1];
   assign bus.rdata0   = rdata_q[0];
   assign bus.rdata1   = rdata_q[1];
   assign bus.mem_we   = cmd_vld_q & cmd_q.we;
   assign bus.mem_addr = cmd_q.addr;
   assign bus.mem_wd   = cmd_q.wdata;
   assign bus.busy     = cmd_vld_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed requests, queued expectations, negedge monitor.
module tb_dmem_port_arbiter;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] exp;} cmd_t;
   typedef struct {logic [31:0] data; int cyc;} rsp_t;
   typedef struct {logic we; logic [31:0] addr; logic [31:0] wd; int cyc;} iss_t;

   cmd_t q0[$], q1[$];
   rsp_t sb0[$], sb1[$];
   iss_t iq[$];
   int   gport[$], gcyc[$];
   int   checks = 0, errors = 0;
   int   cyc = 0, we_cnt = 0, rel_cyc = 0;
   iss_t mi;
   rsp_t mr;

   // Data_Memory model: combinational read, write on clock edge, plus a preload port.
   logic [31:0] mem [0:255];
   logic        bd_we  = 1'b0;
   logic [7:0]  bd_idx = '0;
   logic [31:0] bd_dat = '0;
   always @(posedge clk) begin
      if (bd_we)            mem[bd_idx] <= bd_dat;
      else if (bus.mem_we)  mem[bus.mem_addr[9:2]] <= bus.mem_wd;
   end
   assign bus.mem_rd = mem[bus.mem_addr[9:2]];

   always @(posedge clk) cyc <= cyc + 1;

   property p_hold0;
      @(posedge clk) disable iff (!reset)
      (bus.req0 && !bus.gnt0) |=> (!bus.req0 || $stable({bus.we0, bus.addr0, bus.wdata0}));
   endproperty
   property p_hold1;
      @(posedge clk) disable iff (!reset)
      (bus.req1 && !bus.gnt1) |=> (!bus.req1 || $stable({bus.we1, bus.addr1, bus.wdata1}));
   endproperty
   a_hold0: assert property (p_hold0) else $error("port 0 request fields changed while waiting");
   a_hold1: assert property (p_hold1) else $error("port 1 request fields changed while waiting");

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_val(input int i);
      case (i)
         8:       return 32'h0BAD_F00D;
         12:      return 32'h3030_3030;
         16:      return 32'hDEAD_BEEF;
         default: return {16'hC0DE, 16'(i * 4)};
      endcase
   endfunction

   task automatic push(input int p, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] ex);
      cmd_t c;
      c = '{we, a, wd, ex};
      if (p == 0) q0.push_back(c);
      else        q1.push_back(c);
   endtask

   task automatic accept(input int p, input cmd_t c);
      rsp_t r;
      iss_t s;
      gport.push_back(p);
      gcyc.push_back(cyc);
      s = '{c.we, c.addr, c.wdata, cyc + 1};
      iq.push_back(s);
      if (!c.we) begin
         r = '{c.exp, cyc + 2};
         if (p == 0) sb0.push_back(r);
         else        sb1.push_back(r);
      end
   endtask

   // Presents queue heads, consumes on grant; bounded by a cycle budget.
   task automatic run(input int budget);
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
         bus.req0 = (q0.size() != 0);
         if (q0.size() != 0) begin bus.we0 = q0[0].we; bus.addr0 = q0[0].addr; bus.wdata0 = q0[0].wdata; end
         bus.req1 = (q1.size() != 0);
         if (q1.size() != 0) begin bus.we1 = q1[0].we; bus.addr1 = q1[0].addr; bus.wdata1 = q1[0].wdata; end
         @(negedge clk);
         chk("gnt_onehot", 64'(bus.gnt0 & bus.gnt1), 64'd0);
         if (bus.gnt0) begin
            if (q0.size() == 0) chk("gnt0_without_req", 64'd1, 64'd0);
            else accept(0, q0.pop_front());
         end
         if (bus.gnt1) begin
            if (q1.size() == 0) chk("gnt1_without_req", 64'd1, 64'd0);
            else accept(1, q1.pop_front());
         end
         @(posedge clk); #1;
         n++;
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      chk("run_pending_after_budget", 64'(q0.size() + q1.size()), 64'd0);
      q0.delete();
      q1.delete();
   endtask

   task automatic drain();
      repeat (4) @(posedge clk);
      #1;
      chk("sb0_missing_rvalid", 64'(sb0.size()), 64'd0);
      chk("sb1_missing_rvalid", 64'(sb1.size()), 64'd0);
      chk("issue_missing", 64'(iq.size()), 64'd0);
   endtask

   task automatic clear_log();
      gport.delete();
      gcyc.delete();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_gnt0"},     64'(bus.gnt0),     64'd0);
      chk({tag, "_gnt1"},     64'(bus.gnt1),     64'd0);
      chk({tag, "_rvalid0"},  64'(bus.rvalid0),  64'd0);
      chk({tag, "_rvalid1"},  64'(bus.rvalid1),  64'd0);
      chk({tag, "_rdata0"},   64'(bus.rdata0),   64'd0);
      chk({tag, "_rdata1"},   64'(bus.rdata1),   64'd0);
      chk({tag, "_mem_we"},   64'(bus.mem_we),   64'd0);
      chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
      chk({tag, "_mem_wd"},   64'(bus.mem_wd),   64'd0);
      chk({tag, "_busy"},     64'(bus.busy),     64'd0);
   endtask

   // Monitor: pops the issue and response scoreboards whenever the DUT presents them.
   always @(negedge clk) begin
      if (reset) begin
         if (bus.mem_we) we_cnt++;
         if (bus.busy) begin
            if (iq.size() == 0) chk("issue_unexpected", 64'd1, 64'd0);
            else begin
               mi = iq.pop_front();
               chk("issue_cycle", 64'(cyc), 64'(mi.cyc));
               chk("mem_addr", 64'(bus.mem_addr), 64'(mi.addr));
               chk("mem_we", 64'(bus.mem_we), 64'(mi.we));
               chk("mem_wd", 64'(bus.mem_wd), 64'(mi.wd));
            end
         end else chk("idle_mem_we", 64'(bus.mem_we), 64'd0);
         if (bus.rvalid0) begin
            if (sb0.size() == 0) chk("rvalid0_unexpected", 64'd1, 64'd0);
            else begin
               mr = sb0.pop_front();
               chk("rvalid0_cycle", 64'(cyc), 64'(mr.cyc));
               chk("rdata0", 64'(bus.rdata0), 64'(mr.data));
            end
         end
         if (bus.rvalid1) begin
            if (sb1.size() == 0) chk("rvalid1_unexpected", 64'd1, 64'd0);
            else begin
               mr = sb1.pop_front();
               chk("rvalid1_cycle", 64'(cyc), 64'(mr.cyc));
               chk("rdata1", 64'(bus.rdata1), 64'(mr.data));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      int exp_ord[8];
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
      for (int i = 0; i < 256; i++) begin
         bd_we = 1'b1; bd_idx = 8'(i); bd_dat = init_val(i);
         @(posedge clk); #1;
      end
      bd_we = 1'b0;

      // Reset state, with requests asserted to show grants stay low.
      bus.req0 = 1'b1; bus.req1 = 1'b1; #1;
      check_zero("reset");
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      reset = 1'b1;
      rel_cyc = cyc;

      // Single read on port 0, first cycle after reset release.
      clear_log();
      push(0, 1'b0, 32'h40, 32'h1111_1111, 32'hDEAD_BEEF);
      run(10); drain();
      chk("t1_grants", 64'(gport.size()), 64'd1);
      if (gport.size() == 1) begin
         chk("t1_port", 64'(gport[0]), 64'd0);
         chk("t1_first_cycle", 64'(gcyc[0]), 64'(rel_cyc));
      end

      // Write then back-to-back read-back on port 1.
      clear_log();
      w0 = we_cnt;
      push(1, 1'b1, 32'h80, 32'h1234_5678, 32'h0);
      push(1, 1'b0, 32'h80, 32'h0000_0000, 32'h1234_5678);
      run(10); drain();
      chk("t2_we_pulses", 64'(we_cnt - w0), 64'd1);
      chk("t2_grants", 64'(gport.size()), 64'd2);
      if (gport.size() == 2) begin
         chk("t2_port_a", 64'(gport[0]), 64'd1);
         chk("t2_port_b", 64'(gport[1]), 64'd1);
         chk("t2_consecutive", 64'(gcyc[1] - gcyc[0]), 64'd1);
      end

      // Contention: both ports hold four reads each.
      clear_log();
      for (int i = 0; i < 4; i++) begin
         push(0, 1'b0, 32'(i * 4), 32'hF000_0000 + 32'(i), init_val(i));
         push(1, 1'b0, 32'h100 + 32'(i * 4), 32'hE000_0000 + 32'(i), init_val(64 + i));
      end
`ifdef ARB_CORE_PRIO_EN
      exp_ord = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
      exp_ord = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
      run(20); drain();
      chk("t3_grants", 64'(gport.size()), 64'd8);
      for (int i = 0; i < 8 && i < gport.size(); i++) chk("t3_order", 64'(gport[i]), 64'(exp_ord[i]));
      if (gport.size() == 8) chk("t3_span", 64'(gcyc[7] - gcyc[0]), 64'd7);

      // Write on port 0 alongside a read on port 1.
      clear_log();
      push(0, 1'b1, 32'h10, 32'hAAAA_5555, 32'h0);
      push(1, 1'b0, 32'h20, 32'h5A5A_5A5A, 32'h0BAD_F00D);
      run(10); drain();
      chk("t4_grants", 64'(gport.size()), 64'd2);
      chk("t4_mem_10", 64'(mem[4]), 64'hAAAA_5555);

      // Reset between the accept edge and the issue edge.
      clear_log();
      push(0, 1'b1, 32'h30, 32'hFFFF_0000, 32'h0);
      run(10);
      reset = 1'b0;
      iq.delete(); sb0.delete(); sb1.delete();
      bus.req1 = 1'b1; #1;
      check_zero("midrst");
      bus.req1 = 1'b0;
      @(posedge clk); #1;
      chk("t5_mem_30", 64'(mem[12]), 64'h3030_3030);
      reset = 1'b1;
      rel_cyc = cyc;
      clear_log();
      push(0, 1'b0, 32'h30, 32'h0, 32'h3030_3030);
      push(1, 1'b0, 32'h44, 32'h0, init_val(17));
      run(10); drain();
      chk("t5_grants", 64'(gport.size()), 64'd2);
      if (gport.size() == 2) begin
         chk("t5_first_port", 64'(gport[0]), 64'd0);
         chk("t5_second_port", 64'(gport[1]), 64'd1);
         chk("t5_first_cycle", 64'(gcyc[0]), 64'(rel_cyc));
      end

      // Idle hold after a read of 0x44.
      clear_log();
      push(0, 1'b0, 32'h44, 32'h4444_0000, init_val(17));
      run(10); drain();
      repeat (5) begin
         @(negedge clk);
         chk("t6_mem_we", 64'(bus.mem_we), 64'd0);
         chk("t6_mem_addr", 64'(bus.mem_addr), 64'h44);
         chk("t6_mem_wd", 64'(bus.mem_wd), 64'h4444_0000);
         chk("t6_busy", 64'(bus.busy), 64'd0);
         chk("t6_rdata0_held", 64'(bus.rdata0), 64'(init_val(17)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
